// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcodes and funct7 values.
// The ALU, ALU control and issue stage import these constants from here.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASS = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // alt selects SUB for funct3 000 and SRA for funct3 101.
  function automatic logic [ALU_CTRL_W-1:0] funct3_to_alu(input logic [2:0] f3,
                                                         input logic       alt);
    logic [ALU_CTRL_W-1:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU operation code and A/B operand selection.
// Illegal encodings collapse to ADD with zero operands and no register write.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic [XLEN-1:0]   pc,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  output logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   a,
  output logic [XLEN-1:0]   b,
  output logic [4:0]        rd,
  output logic              rd_we,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [ALU_CTRL_W-1:0] code;
  logic writes_rd;
  logic unused_fields;

  assign opcode        = instr[6:0];
  assign rd            = instr[11:7];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^instr[24:15];

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    code      = ALU_ADD;
    a         = '0;
    b         = '0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        code      = funct3_to_alu(funct3, funct7 == F7_ALT);
        a         = rs1_data;
        b         = rs2_data;
        writes_rd = 1'b1;
        illegal   = !((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        code      = funct3_to_alu(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        a         = rs1_data;
        b         = imm;
        writes_rd = 1'b1;
        if (funct3 == 3'b001)
          illegal = (funct7 != F7_BASE);
        else if (funct3 == 3'b101)
          illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
      end
      OPC_LOAD, OPC_STORE: begin
        a         = rs1_data;
        b         = imm;
        writes_rd = (opcode == OPC_LOAD);
      end
      OPC_LUI: begin
        code      = ALU_PASS;
        b         = imm;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        a         = pc;
        b         = imm;
        writes_rd = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        a         = pc;
        b         = XLEN'(4);
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        code = ALU_SUB;
        a    = rs1_data;
        b    = rs2_data;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      code      = ALU_ADD;
      a         = '0;
      b         = '0;
      writes_rd = 1'b0;
    end
  end

  assign ctrl  = CTRL_W'(code);
  assign rd_we = writes_rd && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an instruction and presents it to the ALU through
// a registered valid/ready slot backed by a one-entry skid buffer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic [4:0]        out_rd,
  output logic              out_rd_we,
  output logic              out_illegal
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [4:0]        rd;
    logic              rd_we;
    logic              illegal;
  } slot_t;

  slot_t dec, main_q, skid_q;
  logic  main_valid, skid_valid;
  logic  accept, main_free;

  alu_op_decode #(.XLEN(XLEN), .CTRL_W(CTRL_W)) u_decode (
    .pc       (in_pc),
    .instr    (in_instr),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .imm      (in_imm),
    .ctrl     (dec.ctrl),
    .a        (dec.a),
    .b        (dec.b),
    .rd       (dec.rd),
    .rd_we    (dec.rd_we),
    .illegal  (dec.illegal)
  );

  // in_ready comes straight from a flop, so out_ready never reaches upstream.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  // NOTE: the payload registers are reset too, because the outputs must read
  // zero after reset rather than whatever was left over from before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // Skid is older than anything arriving now, so it refills main first.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid    = main_valid;
  assign out_a        = main_q.a;
  assign out_b        = main_q.b;
  assign out_alu_ctrl = main_q.ctrl;
  assign out_rd       = main_q.rd;
  assign out_rd_we    = main_q.rd_we;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure through the
// skid buffer, flush and asynchronous reset, all with hand-computed expectations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(.XLEN(32), .CTRL_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_alu_ctrl (out_alu_ctrl),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_imm      = imm;
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_a",     out_a,          32'd0);
    check("rst_ctrl",      32'(out_alu_ctrl), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back decode vectors, out_ready held high (1/cycle throughput).
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0);       // add x3,x1,x2
    tick();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_ctrl",  32'(out_alu_ctrl), 32'd0);
    check("add_a",     out_a, 32'd5);
    check("add_b",     out_b, 32'd7);
    check("add_rd",    32'(out_rd), 32'd3);
    check("add_we",    32'(out_rd_we), 32'd1);

    drive(32'h40208233, 32'h0, 32'd5, 32'd7, 32'h0);       // sub x4,x1,x2
    tick();
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_ctrl",  32'(out_alu_ctrl), 32'd1);
    check("sub_a",     out_a, 32'd5);
    check("sub_b",     out_b, 32'd7);
    check("sub_rd",    32'(out_rd), 32'd4);

    drive(32'h4030D293, 32'h0, 32'h80000000, 32'h0, 32'h00000403); // srai x5,x1,3
    tick();
    check("srai_ctrl", 32'(out_alu_ctrl), 32'd7);
    check("srai_a",    out_a, 32'h80000000);
    check("srai_b",    out_b, 32'h00000403);

    drive(32'h0030D293, 32'h0, 32'h80000000, 32'h0, 32'h00000003); // srli
    tick();
    check("srli_ctrl", 32'(out_alu_ctrl), 32'd6);
    check("srli_ill",  32'(out_illegal), 32'd0);

    drive(32'h6030D293, 32'h0, 32'h80000000, 32'h0, 32'h00000603); // bad funct7
    tick();
    check("badsh_valid", 32'(out_valid), 32'd1);
    check("badsh_ill",   32'(out_illegal), 32'd1);
    check("badsh_we",    32'(out_rd_we), 32'd0);
    check("badsh_a",     out_a, 32'd0);

    drive(32'h123452B7, 32'h0, 32'h0, 32'h0, 32'h12345000); // lui x5
    tick();
    check("lui_ctrl", 32'(out_alu_ctrl), 32'd10);
    check("lui_a",    out_a, 32'd0);
    check("lui_b",    out_b, 32'h12345000);
    check("lui_rd",   32'(out_rd), 32'd5);

    drive(32'h008000EF, 32'h00000100, 32'h0, 32'h0, 32'h8); // jal x1,8
    tick();
    check("jal_ctrl", 32'(out_alu_ctrl), 32'd0);
    check("jal_a",    out_a, 32'h00000100);
    check("jal_b",    out_b, 32'd4);
    check("jal_we",   32'(out_rd_we), 32'd1);

    drive(32'h0020A023, 32'h0, 32'h1000, 32'd9, 32'h0); // sw x2,0(x1)
    tick();
    check("sw_ctrl", 32'(out_alu_ctrl), 32'd0);
    check("sw_a",    out_a, 32'h1000);
    check("sw_we",   32'(out_rd_we), 32'd0);

    drive(32'h00208463, 32'h0, 32'd3, 32'd3, 32'h8); // beq x1,x2,8
    tick();
    check("beq_ctrl", 32'(out_alu_ctrl), 32'd1);
    check("beq_b",    out_b, 32'd3);
    check("beq_we",   32'(out_rd_we), 32'd0);

    drive(32'h00208033, 32'h0, 32'd1, 32'd2, 32'h0); // add x0,x1,x2
    tick();
    check("addx0_we", 32'(out_rd_we), 32'd0);

    drive(32'h0000007F, 32'h0, 32'd1, 32'd2, 32'd3); // unknown opcode
    tick();
    check("unk_valid", 32'(out_valid), 32'd1);
    check("unk_ill",   32'(out_illegal), 32'd1);
    check("unk_b",     out_b, 32'd0);

    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: I0 held, I1 in skid, I2 waits upstream; then in-order drain.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd11, 32'd0, 32'h0);
    tick();
    check("bp_i0_a",  out_a, 32'd11);
    check("bp_rdy0",  32'(in_ready), 32'd1);
    drive(32'h002081B3, 32'h0, 32'd22, 32'd0, 32'h0);
    tick();
    check("bp_hold0", out_a, 32'd11);
    check("bp_rdy1",  32'(in_ready), 32'd0);
    drive(32'h002081B3, 32'h0, 32'd33, 32'd0, 32'h0);
    tick();
    check("bp_hold1", out_a, 32'd11);
    check("bp_rdy2",  32'(in_ready), 32'd0);
    check("bp_vld2",  32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_out_i1", out_a, 32'd22);
    check("bp_rdy3",   32'(in_ready), 32'd1);
    tick();
    check("bp_out_i2", out_a, 32'd33);
    check("bp_vld_i2", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush with main and skid both full and an input pending.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd44, 32'd0, 32'h0);
    tick();
    drive(32'h002081B3, 32'h0, 32'd55, 32'd0, 32'h0);
    tick();
    check("fl_full_rdy", 32'(in_ready), 32'd0);
    drive(32'h002081B3, 32'h0, 32'd66, 32'd0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_rdy",   32'(in_ready),  32'd1);
    out_ready = 1'b1;
    tick();
    check("fl_no_emit", 32'(out_valid), 32'd0);

    // Flush while in_ready=1: the presented input must still be dropped.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd77, 32'd0, 32'h0);
    tick();
    drive(32'h002081B3, 32'h0, 32'd88, 32'd0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2_valid", 32'(out_valid), 32'd0);
    check("fl2_rdy",   32'(in_ready),  32'd1);
    out_ready = 1'b1;
    tick();
    check("fl2_no_emit", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream, observed before any clock edge.
    out_ready = 1'b0;
    drive(32'h40208233, 32'h0, 32'd9, 32'd4, 32'h0);
    tick();
    drive(32'h40208233, 32'h0, 32'd8, 32'd4, 32'h0);
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_a",     out_a, 32'd0);
    check("ar_b",     out_b, 32'd0);
    check("ar_ctrl",  32'(out_alu_ctrl), 32'd0);
    check("ar_rd",    32'(out_rd), 32'd0);
    check("ar_rdy",   32'(in_ready), 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ar_post_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX producer for the EX-stage ALU: decodes a 32-bit RV32I instruction into the 4-bit ALU operation code and selects the A/B operands.
- Registers the decoded operation and operands into a valid/ready pipeline slot with a one-entry skid buffer.
- Sits between the decode/register-read stage and the ALU; it is the driving end of the ALU's a/b/alu_ctrl interface.

Parameters:
- XLEN, 32, operand/PC width.
- CTRL_W, 4, ALU operation code width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill (branch mispredict/trap).
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_pc  in  XLEN  instruction PC.
- in_instr  in  32  raw instruction.
- in_rs1_data  in  XLEN  register-file rs1 value.
- in_rs2_data  in  XLEN  register-file rs2 value.
- in_imm  in  XLEN  sign-extended immediate from the immediate generator.
- out_valid  out  1  EX slot valid.
- out_ready  in  1  EX accepts.
- out_a  out  XLEN  ALU operand A.
- out_b  out  XLEN  ALU operand B.
- out_alu_ctrl  out  CTRL_W  ALU operation code.
- out_rd  out  5  destination register.
- out_rd_we  out  1  register write enable (0 for STORE, BRANCH, illegal, rd==0).
- out_illegal  out  1  unsupported/illegal encoding.

Behaviour:
- Code map: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS=10. Values 11–15 are never emitted.
- OP (0110011): a=rs1, b=rs2.
  - funct3 000 → ADD, or SUB if funct7=0100000.
  - funct3 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - funct3 101 → SRL, or SRA if funct7=0100000.
  - funct3 110 → OR; 111 → AND.
  - funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
- OP-IMM (0010011): a=rs1, b=in_imm, same funct3 map, never SUB.
  - Shifts (001/101) require funct7 0000000 (or 0100000 for 101 → SRA); otherwise illegal.
- LOAD (0000011) / STORE (0100011): ADD, a=rs1, b=in_imm.
- LUI (0110111): PASS, a=0, b=in_imm.
- AUIPC (0010111): ADD, a=pc, b=in_imm.
- JAL (1101111) / JALR (1100111): ADD, a=pc, b=4 (link value).
- BRANCH (1100011): SUB, a=rs1, b=rs2, rd_we=0.
- Any other opcode: illegal=1, ctrl=ADD, a=b=0, rd_we=0. It still flows as a valid slot so the trap logic can see it.
- Latency: accepted instruction appears on out_* the next cycle; sustained throughput is 1/cycle when out_ready=1.
- Handshake:
  - Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
  - out_* stay stable while out_valid&!out_ready.
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
- Skid buffer:
  - If the main slot is held and a new instruction is accepted, it goes to skid.
  - When main drains, skid moves to main in the same cycle.
  - Order is always preserved; no loss, no duplication.
- Flush:
  - Clears main and skid valid at the clock edge; the input presented in the flush cycle is dropped.
  - in_ready=1 the following cycle.
  - Flush has priority over all simultaneous transfers.
- Reset (async assert, sync release): out_valid=0, in_ready=1, out_a=out_b=0, out_alu_ctrl=0, out_rd=0, out_rd_we=0, out_illegal=0, skid empty.
- Reset mid-stream discards all held instructions.

Decomposition:
- Shared package `alu_pkg` holds:
  - ALU code localparams (ADD..PASS), shared with the ALU and ALU_Control.
  - Opcode constants.
  - funct7 constants F7_BASE=0000000 and F7_ALT=0100000.
- One natural sub-module, `alu_op_decode`: purely combinational instr/pc/rs/imm → {ctrl, a, b, rd, rd_we, illegal}. The top module holds the skid/handshake registers.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle out_valid=1, ctrl=0, a=5, b=7, rd=3, rd_we=1.
- sub x4,x1,x2 (0x40208233), rs1=5, rs2=7 → ctrl=1, a=5, b=7, rd=4.
- srai x5,x1,3 (0x4030D293), in_imm=0x403, rs1=0x80000000 → ctrl=7, b=0x00000403. Encoding 0x0030D293 (srli) → ctrl=6. Encoding 0x6030D293 → illegal=1, rd_we=0.
- lui x5 (0x123452B7), in_imm=0x12345000 → ctrl=10, b=0x12345000. jal at pc=0x100 → ctrl=0, a=0x100, b=4.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while streaming I0, I1, I2.
  - Required: I0 is held on out_*; I1 is captured in skid; in_ready=0 after I1; I2 is held upstream.
  - On out_ready=1: I0, I1, I2 emerge in order, one per cycle.
- Flush/reset:
  - flush asserted with main+skid full and in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emitted.
  - rst_n pulsed low mid-stream → all outputs are 0 immediately (asynchronous).
